// File: rtl/ans_pkg.sv
// Shared rANS definitions: widths, model-port request codes,
// encoder FSM states and the encoder register bundle.
package ans_pkg;

  localparam int SYM_WIDTH   = 4;
  localparam int STATE_WIDTH = 16;
  localparam int CNT_WIDTH   = 8;
  localparam int SYM_COUNT   = 16;
  localparam int RES_WIDTH   = CNT_WIDTH + SYM_WIDTH;
  localparam int FLUSH_NIBS  = STATE_WIDTH / SYM_WIDTH;
  localparam int NIB_W       = $clog2(FLUSH_NIBS);

  localparam logic [1:0] READ_TYPE_NONE = 2'd0;
  localparam logic [1:0] READ_TYPE_PMF  = 2'd1;
  localparam logic [1:0] READ_TYPE_CMF  = 2'd2;
  localparam logic [1:0] READ_TYPE_ICMF = 2'd3;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_PMF,
    S_CMF,
    S_RENORM,
    S_DIVIDE,
    S_UPDATE,
    S_FLUSH_STATE,
    S_FLUSH_STACK,
    S_ERROR
  } state_t;

  typedef struct packed {
    state_t                 st;
    logic [SYM_WIDTH-1:0]   s;
    logic                   last;
    logic [RES_WIDTH-1:0]   f;
    logic [RES_WIDTH-1:0]   c;
    logic [STATE_WIDTH-1:0] x;
    logic [STATE_WIDTH-1:0] m;
    logic [NIB_W-1:0]       nib;
    logic                   in_rdy;
    logic                   out_vld;
    logic [SYM_WIDTH-1:0]   out;
    logic [1:0]             rtype;
    logic [RES_WIDTH-1:0]   rquery;
    logic                   err;
  } enc_regs_t;

  // x >= (f << SYM_WIDTH), evaluated wide enough to never overflow
  function automatic logic needs_renorm(
    input logic [STATE_WIDTH-1:0] x,
    input logic [RES_WIDTH-1:0]   f
  );
    localparam int CW = STATE_WIDTH + RES_WIDTH;
    logic [CW-1:0] lhs;
    logic [CW-1:0] rhs;
    lhs = {{RES_WIDTH{1'b0}}, x};
    rhs = {{(STATE_WIDTH - SYM_WIDTH){1'b0}}, f, {SYM_WIDTH{1'b0}}};
    return lhs >= rhs;
  endfunction

endpackage

// File: rtl/ans_divider.sv
// Sequential restoring divider, one quotient bit per enabled cycle.
// done stays high from completion until the next start.
module ans_divider
  import ans_pkg::*;
#(
  parameter int W = STATE_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done_q;
  logic          ge;

  assign rem_sh = {rem, quo[W-1]};
  assign diff   = rem_sh - {1'b0, divisor};
  assign ge     = ~diff[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done_q <= 1'b0;
    end else if (ena) begin
      if (start) begin
        quo    <= dividend;
        rem    <= '0;
        cnt    <= CW'(W);
        busy   <= 1'b1;
        done_q <= 1'b0;
      end else if (busy) begin
        if (ge) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= rem_sh[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy   <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/ans_encoder.sv
// rANS stream encoder: model lookups, renorm LIFO, divide/update,
// then final state LSB-first followed by the popped LIFO.
module ans_encoder
  import ans_pkg::*;
#(
  parameter int STACK_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [SYM_WIDTH-1:0] in,
  input  logic                 in_vld,
  input  logic                 in_last,
  output logic                 in_rdy,
  output logic [SYM_WIDTH-1:0] out,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [1:0]           read_type,
  output logic [RES_WIDTH-1:0] read_query,
  input  logic [RES_WIDTH-1:0] read_result,
  input  logic                 read_rdy,
  output logic                 err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ?
                         $clog2(STACK_DEPTH) : 1;

  enc_regs_t r;
  enc_regs_t n;

  logic [SYM_WIDTH-1:0]   mem [STACK_DEPTH];
  logic [SP_W-1:0]        sp;
  logic [IDX_W-1:0]       top_idx;
  logic [SYM_WIDTH-1:0]   top;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   rd_fire;
  logic                   div_start;
  logic                   div_done;
  logic [STATE_WIDTH-1:0] quo;
  logic [STATE_WIDTH-1:0] rem;
  logic [STATE_WIDTH-1:0] upd;

  assign full    = sp == SP_W'(STACK_DEPTH);
  assign empty   = sp == '0;
  assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
  assign top     = mem[top_idx];
  assign rd_fire = (r.rtype != READ_TYPE_NONE) && read_rdy;
  assign upd     = quo * r.m + STATE_WIDTH'(r.c) + rem;

  ans_divider #(.W(STATE_WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (div_start),
    .dividend  (r.x),
    .divisor   (STATE_WIDTH'(r.f)),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (ena) begin
      if (push)
        sp <= sp + SP_W'(1);
      else if (pop)
        sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ena && push)
      mem[sp[IDX_W-1:0]] <= r.x[SYM_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r <= '0;
    else if (ena)
      r <= n;
  end

  // Model requests and nibbles are registered; a finished handshake
  // leaves them idle for one cycle before the next one is raised.
  always_comb begin
    n         = r;
    push      = 1'b0;
    pop       = 1'b0;
    div_start = 1'b0;
    unique case (r.st)
      S_INIT: begin
        if (rd_fire) begin
          n.rtype  = READ_TYPE_NONE;
          n.m      = STATE_WIDTH'(read_result);
          n.x      = STATE_WIDTH'(read_result);
          n.in_rdy = 1'b1;
          n.st     = S_IDLE;
        end else if (r.rtype == READ_TYPE_NONE) begin
          n.rtype  = READ_TYPE_CMF;
          n.rquery = RES_WIDTH'(SYM_COUNT - 1);
        end
      end
      S_IDLE: begin
        if (in_vld && r.in_rdy) begin
          n.s      = in;
          n.last   = in_last;
          n.in_rdy = 1'b0;
          n.st     = S_PMF;
        end
      end
      S_PMF: begin
        if (rd_fire) begin
          n.rtype = READ_TYPE_NONE;
          n.f     = read_result;
          if (read_result == '0) begin
            n.err = 1'b1;
            n.st  = S_ERROR;
          end else begin
            n.st = S_CMF;
          end
        end else if (r.rtype == READ_TYPE_NONE) begin
          n.rtype  = READ_TYPE_PMF;
          n.rquery = {{CNT_WIDTH{1'b0}}, r.s};
        end
      end
      S_CMF: begin
        if (r.s == '0) begin
          n.c  = '0;
          n.st = S_RENORM;
        end else if (rd_fire) begin
          n.rtype = READ_TYPE_NONE;
          n.c     = read_result;
          n.st    = S_RENORM;
        end else if (r.rtype == READ_TYPE_NONE) begin
          n.rtype  = READ_TYPE_CMF;
          n.rquery = {{CNT_WIDTH{1'b0}},
                      r.s - SYM_WIDTH'(1)};
        end
      end
      S_RENORM: begin
        if (needs_renorm(r.x, r.f)) begin
          if (full) begin
            n.err = 1'b1;
            n.st  = S_ERROR;
          end else begin
            push = 1'b1;
            n.x  = r.x >> SYM_WIDTH;
          end
        end else begin
          div_start = 1'b1;
          n.st      = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (div_done)
          n.st = S_UPDATE;
      end
      S_UPDATE: begin
        n.x = upd;
        if (r.last) begin
          n.nib = '0;
          n.st  = S_FLUSH_STATE;
        end else begin
          n.in_rdy = 1'b1;
          n.st     = S_IDLE;
        end
      end
      S_FLUSH_STATE: begin
        if (r.out_vld) begin
          if (out_rdy) begin
            n.out_vld = 1'b0;
            n.x       = r.x >> SYM_WIDTH;
            n.nib     = r.nib + NIB_W'(1);
            if (r.nib == NIB_W'(FLUSH_NIBS - 1))
              n.st = S_FLUSH_STACK;
          end
        end else begin
          n.out_vld = 1'b1;
          n.out     = r.x[SYM_WIDTH-1:0];
        end
      end
      S_FLUSH_STACK: begin
        if (r.out_vld) begin
          if (out_rdy) begin
            n.out_vld = 1'b0;
            pop       = 1'b1;
          end
        end else if (empty) begin
          n.x      = r.m;
          n.in_rdy = 1'b1;
          n.st     = S_IDLE;
        end else begin
          n.out_vld = 1'b1;
          n.out     = top;
        end
      end
      S_ERROR: begin
        n.in_rdy  = 1'b0;
        n.out_vld = 1'b0;
        n.rtype   = READ_TYPE_NONE;
      end
      default: begin
        n.err = 1'b1;
        n.st  = S_ERROR;
      end
    endcase
  end

  assign in_rdy     = r.in_rdy;
  assign out        = r.out;
  assign out_vld    = r.out_vld;
  assign read_type  = r.rtype;
  assign read_query = r.rquery;
  assign err        = r.err;

endmodule

// File: tb/tb_ans_encoder.sv
// Bench for ans_encoder: directed and randomized blocks checked
// against a plain-arithmetic rANS reference and a protocol monitor.
module tb_ans_encoder;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [3:0]  sym = '0;
  logic        in_vld = 1'b0;
  logic        in_last = 1'b0;
  logic        in_rdy;
  logic [3:0]  out_nib;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [1:0]  read_type;
  logic [11:0] read_query;
  logic [11:0] read_result;
  logic        read_rdy;
  logic        err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pmf [16];
  int rd_delay = 0;
  int rd_wait = 0;
  int rdy_mode = 0;
  int got [$];
  int first_out_cyc = -1;
  int acc_cyc = 0;
  int acc_cnt = 0;

  ans_encoder #(.STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in          (sym),
    .in_vld      (in_vld),
    .in_last     (in_last),
    .in_rdy      (in_rdy),
    .out         (out_nib),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .read_type   (read_type),
    .read_query  (read_query),
    .read_result (read_result),
    .read_rdy    (read_rdy),
    .err         (err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cmf(input int k);
    int s = 0;
    for (int i = 0; i <= k && i < 16; i++) s += pmf[i];
    return s;
  endfunction

  function automatic int model_ans(input logic [1:0] t, input int q);
    if (t == 2'd1) return (q < 16) ? pmf[q] : 0;
    if (t == 2'd2) return cmf(q);
    return 0;
  endfunction

  always_comb begin
    read_rdy    = (read_type != 2'd0) && (rd_wait >= rd_delay);
    read_result = 12'(model_ans(read_type, int'(read_query)));
  end

  always @(posedge clk) begin
    if (!rst_n || read_type == 2'd0) rd_wait <= 0;
    else if (ena) rd_wait <= rd_wait + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_rdy = 1'($urandom_range(0, 1));
  end

  // Handshake monitor and nibble collector
  logic       p_valid = 1'b0;
  logic       p_rd_hold = 1'b0;
  logic       p_rd_fire = 1'b0;
  logic       p_out_hold = 1'b0;
  logic       p_out_fire = 1'b0;
  logic       p_in_fire = 1'b0;
  logic [1:0]  p_rt = '0;
  logic [11:0] p_rq = '0;
  logic [3:0]  p_out = '0;

  always @(negedge clk) begin
    if (rst_n && p_valid) begin
      if (p_rd_hold) begin
        chk("rd_type_hold", 32'(read_type), 32'(p_rt));
        chk("rd_query_hold", 32'(read_query), 32'(p_rq));
      end
      if (p_rd_fire) chk("rd_gap", 32'(read_type), 32'd0);
      if (p_out_hold) begin
        chk("out_vld_hold", 32'(out_vld), 32'd1);
        chk("out_hold", 32'(out_nib), 32'(p_out));
      end
      if (p_out_fire) chk("out_gap", 32'(out_vld), 32'd0);
      if (p_in_fire) chk("in_rdy_drop", 32'(in_rdy), 32'd0);
    end
    if (rst_n && out_vld && first_out_cyc < 0) first_out_cyc = cyc;
    if (rst_n && ena && out_vld && out_rdy) got.push_back(int'(out_nib));
    p_valid    = rst_n;
    p_rd_hold  = (read_type != 2'd0) && !(ena && read_rdy);
    p_rd_fire  = ena && (read_type != 2'd0) && read_rdy;
    p_out_hold = out_vld && !(ena && out_rdy);
    p_out_fire = ena && out_vld && out_rdy;
    p_in_fire  = ena && in_vld && in_rdy;
    p_rt  = read_type;
    p_rq  = read_query;
    p_out = out_nib;
  end

  // Reference rANS: x starts at M, final symbol is last in sy
  function automatic void ref_encode(input int sy[$], output int eq[$],
                                     output bit e);
    int x, m, f, c;
    int st [$];
    m = cmf(15);
    x = m;
    e = 1'b0;
    eq = {};
    foreach (sy[i]) begin
      f = pmf[sy[i]];
      if (f == 0) begin e = 1'b1; return; end
      c = (sy[i] == 0) ? 0 : cmf(sy[i] - 1);
      while (x >= f * 16) begin
        if (st.size() >= DEPTH) begin e = 1'b1; return; end
        st.push_back(x % 16);
        x = x / 16;
      end
      x = ((x / f) * m + c + x % f) % 65536;
    end
    for (int k = 0; k < 4; k++) begin
      eq.push_back(x % 16);
      x = x / 16;
    end
    while (st.size() > 0) eq.push_back(st.pop_back());
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_vld = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out", 32'(out_nib), 32'd0);
    chk("rst_read_type", 32'(read_type), 32'd0);
    chk("rst_read_query", 32'(read_query), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int s, input bit last);
    int b = 0;
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    sym = 4'(s);
    in_last = last;
    in_vld = 1'b1;
    while (!ok && b < 3000) begin
      @(negedge clk);
      if (ena && in_rdy) ok = 1'b1;
      b++;
    end
    if (!ok) chk("in_rdy_wait", 32'(in_rdy), 32'd1);
    else begin
      acc_cyc = cyc;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_block(input int sy[$], input string tag,
                           output int lat);
    int eq [$];
    bit e;
    int b = 0;
    ref_encode(sy, eq, e);
    got.delete();
    first_out_cyc = -1;
    foreach (sy[i]) send(sy[i], i == sy.size() - 1);
    while (got.size() < eq.size() && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_len"}, 32'(got.size()), 32'(eq.size()));
    foreach (eq[i])
      if (i < got.size()) chk({tag, "_nib"}, 32'(got[i]), 32'(eq[i]));
    b = 0;
    while (!in_rdy && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    lat = first_out_cyc - acc_cyc;
  endtask

  initial begin
    int sy [$];
    int u_exp [6];
    int lat_a, lat_b, lat_x, base, b, n;
    bit e;
    int eq [$];

    u_exp = '{5, 1, 0, 0, 3, 0};
    for (int i = 0; i < 16; i++) pmf[i] = 1;
    do_reset();

    // uniform model
    sy = '{3, 5};
    run_block(sy, "uniform", lat_a);
    foreach (u_exp[i])
      if (i < got.size()) chk("uniform_const", 32'(got[i]), 32'(u_exp[i]));

    // two-symbol model
    for (int i = 0; i < 16; i++) pmf[i] = (i < 2) ? 8 : 0;
    do_reset();
    sy = '{1, 0};
    run_block(sy, "twosym", lat_x);
    chk("twosym_n0", 32'(got.size() > 1 ? got[1] : -1), 32'd5);

    // backpressure mid-flush
    for (int i = 0; i < 16; i++) pmf[i] = 1;
    do_reset();
    sy = '{3, 5};
    fork
      run_block(sy, "bp", lat_x);
      begin
        int held;
        b = 0;
        while (got.size() < 2 && b < 3000) begin @(negedge clk); b++; end
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        b = 0;
        while (!out_vld && b < 100) begin @(negedge clk); b++; end
        held = int'(out_nib);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("bp_vld", 32'(out_vld), 32'd1);
          chk("bp_out", 32'(out_nib), 32'(held));
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
    join

    // ena freeze during DIVIDE
    run_block(sy, "ena_ref", lat_a);
    base = acc_cnt;
    fork
      run_block(sy, "ena", lat_b);
      begin
        b = 0;
        while (acc_cnt < base + 2 && b < 3000) begin @(negedge clk); b++; end
        repeat (10) @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ena = 1'b1;
      end
    join
    chk("ena_delay", 32'(lat_b - lat_a), 32'd5);

    // slow model port
    rd_delay = 7;
    run_block(sy, "slow", lat_x);
    foreach (u_exp[i])
      if (i < got.size()) chk("slow_const", 32'(got[i]), 32'(u_exp[i]));
    rd_delay = 0;

    // randomized models, symbols, backpressure and model delay
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) pmf[i] = $urandom_range(1, 15);
      rd_delay = $urandom_range(0, 3);
      rdy_mode = 1;
      do_reset();
      sy = {};
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) sy.push_back($urandom_range(0, 15));
      run_block(sy, "rand", lat_x);
    end
    rdy_mode = 0;
    out_rdy = 1'b1;
    rd_delay = 0;

    // LIFO exactly full: 32 pushes with uniform model
    for (int i = 0; i < 16; i++) pmf[i] = 1;
    do_reset();
    sy = {};
    for (int k = 0; k < DEPTH; k++) sy.push_back($urandom_range(0, 15));
    run_block(sy, "full", lat_x);

    // LIFO overflow on the 33rd push
    sy = {};
    got.delete();
    for (int k = 0; k < DEPTH + 1; k++) sy.push_back($urandom_range(0, 15));
    ref_encode(sy, eq, e);
    foreach (sy[i]) send(sy[i], 1'b0);
    b = 0;
    while (!err && b < 200) begin @(negedge clk); b++; end
    chk("ovf_err", 32'(err), 32'(e));
    repeat (20) @(negedge clk);
    chk("ovf_in_rdy", 32'(in_rdy), 32'd0);
    chk("ovf_no_out", 32'(got.size()), 32'd0);
    chk("ovf_read_type", 32'(read_type), 32'd0);
    do_reset();
    sy = '{3, 5};
    run_block(sy, "post_ovf", lat_x);

    // zero-frequency symbol
    pmf[7] = 0;
    do_reset();
    got.delete();
    send(7, 1'b0);
    b = 0;
    while (!err && b < 100) begin @(negedge clk); b++; end
    chk("f0_err", 32'(err), 32'd1);
    repeat (20) @(negedge clk);
    chk("f0_in_rdy", 32'(in_rdy), 32'd0);
    chk("f0_out_vld", 32'(out_vld), 32'd0);
    chk("f0_read_type", 32'(read_type), 32'd0);
    chk("f0_no_out", 32'(got.size()), 32'd0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
